uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
- Framing stage placed directly upstream of the UART transmitter.
- Collects a burst of sensor payload bytes into an internal buffer and wraps them in a frame: SOF byte, LEN byte, payload, XOR checksum byte.
- Streams the frame byte by byte into the uart_tx data/valid/ready input, so the serial link carries self-delimiting, checkable packets instead of raw bytes.

Parameters:
- DATA_WIDTH, 8, byte width on both sides; also the LEN and checksum width.
- MAX_LEN, 16, maximum payload bytes per frame; legal range 1 .. 2^DATA_WIDTH-1.
- SOF_BYTE, 8'hAA, start-of-frame marker.

Ports:
- clk  input  1  system clock; the block's only clock.
- rst  input  1  synchronous reset, active-high.
- s_data  input  DATA_WIDTH  payload byte from sensor.
- s_valid  input  1  s_data valid.
- s_last  input  1  qualifies the final payload byte of a frame.
- s_ready  output  1  block can accept a payload byte.
- tx_data  output  DATA_WIDTH  byte to uart_tx (data_from_sensor).
- tx_valid  output  1  tx_data valid (valid_from_sensor).
- tx_ready  input  1  uart_tx accepts a byte (ready_to_sensor).
- busy  output  1  high from the first accepted payload byte until the checksum byte has been accepted.
- overflow  output  1  one-cycle pulse when a frame is force-closed at MAX_LEN without s_last.

Behaviour:
- Reset: all outputs 0 (s_ready 0 during rst). State COLLECT, count 0, checksum register 0, buffer contents don't-care.
- Transfers: input transfer on s_valid&&s_ready. Output transfer on tx_valid&&tx_ready.
- Output stability: while tx_valid=1 and tx_ready=0, tx_data and tx_valid stay stable.
- COLLECT:
  - s_ready=1, tx_valid=0.
  - Each input transfer writes buf[count], count++, chk ^= s_data, busy=1.
  - Closing byte: a transfer with s_last=1, or the transfer that makes count==MAX_LEN. It latches len=count+1 and moves to SEND_SOF on the next cycle.
  - If count reached MAX_LEN with s_last=0: overflow=1 on the cycle after the closing transfer. Following bytes start a new frame; nothing is dropped.
- SEND_SOF: s_ready=0, tx_valid=1, tx_data=SOF_BYTE. On transfer -> SEND_LEN.
- SEND_LEN: tx_data=len. On transfer -> SEND_PAY with rd_idx=0.
- SEND_PAY: tx_data=buf[rd_idx]. On transfer, rd_idx++. Transfer at rd_idx==len-1 -> SEND_CHK.
- SEND_CHK: tx_data = chk ^ len, i.e. the XOR of the LEN byte and all payload bytes, DATA_WIDTH bits. On transfer -> COLLECT; count, chk and busy are cleared in the same edge.
- Latency: first SOF presented (tx_valid=1) one cycle after the closing input transfer. With tx_ready held at 1, a frame occupies exactly len+3 consecutive output cycles.
- Back-to-back: s_ready returns to 1 the cycle after the checksum transfer. No input byte is accepted during SEND_*.
- Empty frames cannot occur: a frame opens only on an accepted byte.
- s_last on a byte that also hits MAX_LEN: normal close, overflow stays 0.
- tx_ready asserted while tx_valid=0: ignored.
- rst asserted mid-collect or mid-send aborts the frame with no partial output. After rst deasserts, the block is in COLLECT with count 0 and emits nothing until a new closing byte.
- Buffer: MAX_LEN x DATA_WIDTH register array. Counters are $clog2(MAX_LEN+1) bits wide.

Test Plan:
- Reset check: hold rst 3 cycles -> s_ready, tx_valid, busy, overflow, tx_data all 0. After release, s_ready=1 and tx_valid=0.
- Basic frame: send 8'h11, 8'h22, 8'h33 (last on 8'h33), tx_ready=1 -> output AA,03,11,22,33,03^11^22^33=8'h03. tx_valid high exactly 6 consecutive cycles, starting 1 cycle after the 8'h33 transfer.
- Single byte: send 8'h5A with last -> output AA,01,5A,5B. s_ready=0 throughout the send and 1 the cycle after the final transfer.
- Overflow (MAX_LEN=16): stream bytes 0x00..0x10 with s_last=0 -> first frame has LEN=8'h10 and payload 00..0F, with a one-cycle overflow pulse. Byte 0x10 becomes the first byte of the next frame.
- Backpressure: in the basic-frame scenario, toggle tx_ready randomly (including 5 low cycles during SEND_PAY) -> identical byte sequence, tx_data stable while stalled, no duplicated or skipped bytes.
- Reset mid-frame: assert rst during SEND_PAY after 1 payload transfer -> tx_valid=0 the next cycle. A following 1-byte frame 8'h01 emits AA,01,01,00 with no stale data.

Source files
------------

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//
// Framing stage that sits directly in front of a byte-wide UART transmitter.
// Payload bytes from a sensor are collected into a small buffer. When a frame
// closes (s_last, or the buffer is full) the block emits
//     SOF_BYTE, LEN, payload[0..LEN-1], CHK
// on a valid/ready byte stream, where CHK is the XOR of LEN and every payload
// byte.
//
// Ports
//   clk       in   system clock (only clock of the block)
//   rst       in   synchronous reset, active-high
//   s_data    in   payload byte from the sensor
//   s_valid   in   s_data valid
//   s_last    in   marks the final payload byte of a frame
//   s_ready   out  block can accept a payload byte (only while collecting)
//   tx_data   out  byte towards uart_tx
//   tx_valid  out  tx_data valid
//   tx_ready  in   uart_tx accepts the byte
//   busy      out  a frame is in progress (first accepted byte .. CHK accepted)
//   overflow  out  one-cycle pulse when a frame was closed at MAX_LEN
//                  without s_last
// -----------------------------------------------------------------------------
module uart_frame_tx #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = DATA_WIDTH'(8'hAA)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  overflow
);

  // Counter width must hold MAX_LEN itself; buffer address only 0..MAX_LEN-1.
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    ST_COLLECT  = 3'd0,
    ST_SEND_SOF = 3'd1,
    ST_SEND_LEN = 3'd2,
    ST_SEND_PAY = 3'd3,
    ST_SEND_CHK = 3'd4
  } state_t;

  state_t                state_reg;
  logic [CW-1:0]         count_reg;     // payload bytes collected so far
  logic [CW-1:0]         last_idx_reg;  // index of the final payload byte
  logic [CW-1:0]         rd_idx_reg;    // index of the payload byte on tx_data
  logic [DATA_WIDTH-1:0] len_reg;
  logic [DATA_WIDTH-1:0] chk_reg;       // running XOR of payload bytes
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic                  tx_valid_reg;
  logic                  s_ready_reg;
  logic                  busy_reg;
  logic                  overflow_reg;

  logic [DATA_WIDTH-1:0] buf_mem [0:MAX_LEN-1];

  logic                  in_fire;
  logic                  tx_fire;
  logic                  at_full;
  logic                  closing;
  logic [CW-1:0]         rd_next;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;

  // s_ready is only ever high in COLLECT, so in_fire implies COLLECT.
  assign in_fire = s_valid && s_ready_reg;
  assign tx_fire = tx_valid_reg && tx_ready;

  // The byte currently being accepted is the MAX_LEN-th one.
  assign at_full = (count_reg == CW'(MAX_LEN - 1));
  assign closing = in_fire && (s_last || at_full);

  assign rd_next = rd_idx_reg + CW'(1);
  assign wr_addr = count_reg[AW-1:0];
  assign rd_addr = rd_next[AW-1:0];

  // Payload storage: plain write port, read only through the registered
  // tx_data path below, so it maps onto RAM-style storage where available.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_mem[wr_addr] <= s_data;
    end
  end

  // Single FSM with registered outputs. tx_data is always loaded one step
  // ahead (on the transfer of the previous byte) so the output stays stable
  // through any amount of backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_COLLECT;
      count_reg    <= '0;
      last_idx_reg <= '0;
      rd_idx_reg   <= '0;
      len_reg      <= '0;
      chk_reg      <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      s_ready_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= 1'b0;

      case (state_reg)
        ST_COLLECT: begin
          s_ready_reg  <= 1'b1;
          tx_valid_reg <= 1'b0;
          if (in_fire) begin
            chk_reg   <= chk_reg ^ s_data;
            busy_reg  <= 1'b1;
            count_reg <= count_reg + CW'(1);
            if (closing) begin
              len_reg      <= DATA_WIDTH'(count_reg) + DATA_WIDTH'(1);
              last_idx_reg <= count_reg;
              // Forced close: the next accepted byte starts a fresh frame.
              overflow_reg <= !s_last;
              s_ready_reg  <= 1'b0;
              tx_valid_reg <= 1'b1;
              tx_data_reg  <= SOF_BYTE;
              state_reg    <= ST_SEND_SOF;
            end
          end
        end

        ST_SEND_SOF: begin
          if (tx_fire) begin
            tx_data_reg <= len_reg;
            state_reg   <= ST_SEND_LEN;
          end
        end

        ST_SEND_LEN: begin
          if (tx_fire) begin
            tx_data_reg <= buf_mem[0];
            rd_idx_reg  <= '0;
            state_reg   <= ST_SEND_PAY;
          end
        end

        ST_SEND_PAY: begin
          if (tx_fire) begin
            if (rd_idx_reg == last_idx_reg) begin
              // chk_reg already covers every payload byte; fold in LEN.
              tx_data_reg <= chk_reg ^ len_reg;
              state_reg   <= ST_SEND_CHK;
            end else begin
              tx_data_reg <= buf_mem[rd_addr];
              rd_idx_reg  <= rd_next;
            end
          end
        end

        ST_SEND_CHK: begin
          if (tx_fire) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            count_reg    <= '0;
            chk_reg      <= '0;
            busy_reg     <= 1'b0;
            s_ready_reg  <= 1'b1;
            state_reg    <= ST_COLLECT;
          end
        end

        default: begin
          state_reg    <= ST_COLLECT;
          tx_valid_reg <= 1'b0;
          s_ready_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_reg;
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
//
// Directed bench for uart_frame_tx. Expected frames are built by a small
// model (SOF, LEN, payload, XOR) and queued when the payload is driven; a
// monitor pops and compares one entry per output transfer. Inputs change 1ns
// after the rising edge; the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_count = 0;

  logic [7:0] exp_q [$];
  logic [7:0] pay_q [$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  uart_frame_tx #(
    .DATA_WIDTH(8),
    .MAX_LEN   (16),
    .SOF_BYTE  (8'hAA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: frame = SOF, LEN, payload, XOR(LEN, payload).
  task automatic push_frame();
    logic [7:0] x;
    x = 8'(pay_q.size());
    exp_q.push_back(8'hAA);
    exp_q.push_back(x);
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      x = x ^ pay_q[i];
    end
    exp_q.push_back(x);
    pay_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    while (!s_ready && n < 300) begin
      step();
      n++;
    end
    chk("s_ready_wait", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
    $display("in  byte %02h last %0b", d, last);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_valid || exp_q.size() != 0) && n < 500) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, (n < 500)}, 32'd1);
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      chk("ready_excl", {31'd0, (s_ready & tx_valid)}, 32'd0);
      if (tx_valid && tx_ready) begin
        $display("out byte %02h", tx_data);
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
        end
        xfer_count++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    int n;
    int base;
    logic stalled;

    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; tx_ready = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_s_ready",  {31'd0, s_ready},  32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
    rst = 1'b0;
    step();
    chk("rel_s_ready",  {31'd0, s_ready},  32'd1);
    chk("rel_tx_valid", {31'd0, tx_valid}, 32'd0);

    // Basic frame: AA 03 11 22 33 03
    tx_ready = 1'b1;
    pay_q = '{8'h11, 8'h22, 8'h33};
    push_frame();
    send_byte(8'h11, 1'b0);
    chk("busy_collect", {31'd0, busy}, 32'd1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    chk("sof_latency", {31'd0, tx_valid}, 32'd1);
    chk("sof_byte", {24'd0, tx_data}, 32'hAA);
    n = 0;
    while (tx_valid === 1'b1 && n < 50) begin
      chk("sready_send", {31'd0, s_ready}, 32'd0);
      n++;
      step();
    end
    chk("basic_cycles", n, 32'd6);
    chk("basic_sready_after", {31'd0, s_ready}, 32'd1);
    chk("basic_busy_after", {31'd0, busy}, 32'd0);
    chk("basic_queue", exp_q.size(), 32'd0);

    // Single byte frame: AA 01 5A 5B
    pay_q = '{8'h5A};
    push_frame();
    send_byte(8'h5A, 1'b1);
    n = 0;
    while (tx_valid === 1'b1 && n < 50) begin
      chk("sready_single", {31'd0, s_ready}, 32'd0);
      n++;
      step();
    end
    chk("single_cycles", n, 32'd4);
    chk("single_sready_after", {31'd0, s_ready}, 32'd1);

    // Overflow: 0x00..0x0F force-close, 0x10 opens the next frame
    for (int i = 0; i < 16; i++) pay_q.push_back(8'(i));
    push_frame();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b0);
      if (i < 15) chk("ovf_early", {31'd0, overflow}, 32'd0);
    end
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    step();
    chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    pay_q = '{8'h10, 8'h20};
    push_frame();
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b1);
    wait_idle();

    // s_last on the 16th byte: normal close, no overflow
    for (int i = 0; i < 16; i++) pay_q.push_back(8'(8'h80 + i));
    push_frame();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), (i == 15));
    chk("full_last_no_ovf", {31'd0, overflow}, 32'd0);
    wait_idle();

    // Backpressure on the basic frame, 5-cycle stall inside the payload
    tx_ready = 1'b0;
    pay_q = '{8'h11, 8'h22, 8'h33};
    push_frame();
    base = xfer_count;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    stalled = 1'b0;
    n = 0;
    while ((tx_valid || exp_q.size() != 0) && n < 300) begin
      if (!stalled && xfer_count == base + 3) begin
        tx_ready = 1'b0;
        repeat (5) step();
        stalled = 1'b1;
        n += 5;
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
    end
    chk("bp_done", {31'd0, (n < 300)}, 32'd1);
    chk("bp_stalled", {31'd0, stalled}, 32'd1);
    chk("bp_count", xfer_count - base, 32'd6);
    tx_ready = 1'b1;
    step();

    // Reset during SEND_PAY after one payload transfer
    pay_q = '{8'h44, 8'h55, 8'h66};
    push_frame();
    base = xfer_count;
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    n = 0;
    while (xfer_count != base + 3 && n < 50) begin
      step();
      n++;
    end
    chk("midrst_reach", xfer_count - base, 32'd3);
    rst = 1'b1;
    step();
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    chk("midrst_sready", {31'd0, s_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_quiet", {31'd0, tx_valid}, 32'd0);
      step();
    end
    pay_q = '{8'h01};
    push_frame();
    send_byte(8'h01, 1'b1);
    wait_idle();

    chk("final_queue", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
